// File: rtl/truth_table_checker_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_checker_pkg
//   Shared definitions for the truth table checker: FSM state encodings,
//   number of input vectors of a 3-input block, legal dwell bounds and the
//   dwell counter width.
// ---------------------------------------------------------------------------
package truth_table_checker_pkg;

    localparam int NUM_VEC   = 8;
    localparam int DWELL_MIN = 2;
    localparam int DWELL_MAX = 15;
    localparam int CNT_W     = 4;   // wide enough for DWELL_MAX-1

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : truth_table_checker_pkg

// File: rtl/truth_table_checker_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
//   Counts the cycles an input vector has been held. tc flags the cycle in
//   which the count has reached DWELL-1, i.e. the compare cycle.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clear  in   restart the count at zero (priority over en)
//   en     in   count this cycle; wraps to zero after the terminal count
//   cnt    out  current count
//   tc     out  terminal count (cnt == DWELL-1)
// ---------------------------------------------------------------------------
module dwell_timer
    import truth_table_checker_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc  = (cnt_q == TC_VAL);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : dwell_timer

// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
//   Walks all 8 input vectors of a 3-input combinational block, holds each
//   for DWELL cycles, and compares the block's response with a golden truth
//   table latched at start.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   run request (ignored while a run is in progress)
//   expected    in   golden truth table, bit i = required output of vector i
//   dut_out     in   response of the block under check
//   a, b, c     out  stimulus, {a,b,c} = vector index (a is MSB)
//   busy        out  run in progress
//   done        out  run complete, held until next start or reset
//   pass        out  done and no mismatches
//   err_count   out  number of mismatching vectors (0..8)
//   first_fail  out  index of first mismatching vector (valid with fail_valid)
//   fail_valid  out  at least one mismatch recorded
// Handshake: start is a level sampled on each rising edge; it launches a run
//   only from IDLE or DONE. done rises on the edge that ends the run and stays
//   high until the next launching edge or reset.
// ---------------------------------------------------------------------------
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int DWELL = 4   // legal range DWELL_MIN..DWELL_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail,
    output logic       fail_valid
);

    localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);
    localparam logic [3:0] MAX_ERR  = 4'(NUM_VEC);

    state_t     state_q,   state_d;
    logic [2:0] vec_q,     vec_d;
    logic [3:0] err_q,     err_d;
    logic [2:0] ff_q,      ff_d;
    logic       fv_q,      fv_d;
    logic [7:0] exp_q,     exp_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;

    logic             start_run;
    logic             run_en;
    logic             tc;
    logic [CNT_W-1:0] cnt;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_run),
        .en    (run_en),
        .cnt   (cnt),
        .tc    (tc)
    );

    assign run_en = (state_q == ST_RUN);

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        err_d     = err_q;
        ff_d      = ff_q;
        fv_d      = fv_q;
        exp_d     = exp_q;
        busy_d    = busy_q;
        done_d    = done_q;
        start_run = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    vec_d     = '0;
                    err_d     = '0;
                    ff_d      = '0;
                    fv_d      = 1'b0;
                    exp_d     = expected;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                // The vector has settled for DWELL-1 cycles by the tc edge.
                if (tc) begin
                    if (dut_out != exp_q[vec_q]) begin
                        if (err_q < MAX_ERR) begin
                            err_d = err_q + 4'd1;
                        end
                        if (!fv_q) begin
                            fv_d = 1'b1;
                            ff_d = vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // busy_q is high exactly in RUN, so it gates the stimulus to zero elsewhere.
    assign {a, b, c}  = busy_q ? vec_q : 3'b000;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = done_q && (err_q == 4'd0);
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;

endmodule : truth_table_checker

// File: tb/tb_truth_table_checker.sv
// ---------------------------------------------------------------------------
// tb_truth_table_checker
//   Directed bench for truth_table_checker with DWELL=4 (32-cycle runs).
//   The block under check is modelled by dut_mode: 0 = 3-input AND,
//   1 = output tied 0, 2 = output tied 1.
// ---------------------------------------------------------------------------
module tb_truth_table_checker;

    localparam int DWELL   = 4;
    localparam int RUN_LEN = 8 * DWELL;
    localparam int BUDGET  = 100;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] expected;
    logic       dut_out;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_fail;
    logic       fail_valid;

    int dut_mode;
    int checks;
    int errors;

    truth_table_checker #(
        .DWELL (DWELL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .expected   (expected),
        .dut_out    (dut_out),
        .a          (a),
        .b          (b),
        .c          (c),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_out = (dut_mode == 0) ? (a & b & c) :
                     (dut_mode == 1) ? 1'b0 : 1'b1;

    // ---------------- driver tasks ----------------
    // Returns at the falling edge right after the start edge.
    task automatic run_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until done is seen, bounded by BUDGET.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({a, b, c, busy, done, pass, fail_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000000", {a, b, c, busy, done, pass, fail_valid});
        end
        checks++;
        if (err_count !== 4'd0 || first_fail !== 3'd0) begin
            errors++;
            $display("FAIL reset_counts got err=%0d ff=%0d want 0 0", err_count, first_fail);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_and_pass();
        dut_mode = 0;
        expected = 8'h80;
        run_start();
        for (int n = 0; n < RUN_LEN; n++) begin
            checks++;
            if ({a, b, c} !== 3'(n / DWELL) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL and_walk cyc=%0d got abc=%0d busy=%b done=%b want abc=%0d busy=1 done=0",
                         n, {a, b, c}, busy, done, n / DWELL);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL and_end got done=%b busy=%b pass=%b want 1 0 1", done, busy, pass);
        end
        checks++;
        if (err_count !== 4'd0 || fail_valid !== 1'b0 || {a, b, c} !== 3'd0) begin
            errors++;
            $display("FAIL and_result got err=%0d fv=%b abc=%0d want 0 0 0", err_count, fail_valid, {a, b, c});
        end
        // done is held while idle in DONE
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL and_hold got done=%b pass=%b want 1 1", done, pass);
        end
    endtask

    task automatic test_tied0();
        int cyc;
        dut_mode = 1;
        expected = 8'h80;
        run_start();
        wait_done(cyc);
        checks++;
        if (cyc !== RUN_LEN) begin
            errors++;
            $display("FAIL tied0_latency got=%0d want=%0d", cyc, RUN_LEN);
        end
        checks++;
        if (err_count !== 4'd1 || first_fail !== 3'd7 || fail_valid !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL tied0_result got err=%0d ff=%0d fv=%b pass=%b want 1 7 1 0",
                     err_count, first_fail, fail_valid, pass);
        end
    endtask

    task automatic test_tied1();
        int cyc;
        dut_mode = 2;
        expected = 8'h00;
        run_start();
        wait_done(cyc);
        checks++;
        if (cyc !== RUN_LEN) begin
            errors++;
            $display("FAIL tied1_latency got=%0d want=%0d", cyc, RUN_LEN);
        end
        checks++;
        if (err_count !== 4'd8 || first_fail !== 3'd0 || fail_valid !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL tied1_result got err=%0d ff=%0d fv=%b pass=%b want 8 0 1 0",
                     err_count, first_fail, fail_valid, pass);
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        int cyc;
        dut_mode = 0;
        expected = 8'h80;
        run_start();
        k = 0;
        while ({a, b, c} !== 3'd3 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ({a, b, c} !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_reach got abc=%0d want 3", {a, b, c});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a, b, c, busy, done, pass, fail_valid} !== 7'b0 || err_count !== 4'd0 || first_fail !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_clear got flags=%b err=%0d ff=%0d want 0",
                     {a, b, c, busy, done, pass, fail_valid}, err_count, first_fail);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_nodone got done=%b busy=%b want 0 0", done, busy);
            end
        end
        run_start();
        wait_done(cyc);
        checks++;
        if (cyc !== RUN_LEN || pass !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_rerun got cyc=%0d pass=%b want %0d 1", cyc, pass, RUN_LEN);
        end
    endtask

    task automatic test_start_held();
        int cyc;
        @(negedge clk);
        dut_mode = 2;
        expected = 8'h00;
        start    = 1'b1;
        @(negedge clk);
        wait_done(cyc);
        checks++;
        if (cyc !== RUN_LEN || err_count !== 4'd8) begin
            errors++;
            $display("FAIL held_norestart got cyc=%0d err=%0d want %0d 8", cyc, err_count, RUN_LEN);
        end
        // start is still high: the next edge relaunches from DONE
        dut_mode = 0;
        expected = 8'h80;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || err_count !== 4'd0 || fail_valid !== 1'b0) begin
            errors++;
            $display("FAIL held_rerun got done=%b busy=%b err=%0d fv=%b want 0 1 0 0",
                     done, busy, err_count, fail_valid);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== RUN_LEN || pass !== 1'b1) begin
            errors++;
            $display("FAIL held_rerun_end got cyc=%0d pass=%b want %0d 1", cyc, pass, RUN_LEN);
        end
    endtask

    task automatic test_expected_change();
        int cyc;
        dut_mode = 0;
        expected = 8'h80;
        run_start();
        repeat (10) @(negedge clk);
        expected = 8'hFF;
        wait_done(cyc);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 4'd0) begin
            errors++;
            $display("FAIL exp_change got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks   = 0;
        errors   = 0;
        dut_mode = 0;
        start    = 1'b0;
        expected = 8'h00;
        rst_n    = 1'b1;

        test_reset();
        test_and_pass();
        test_tied0();
        test_tied1();
        test_reset_mid_run();
        test_start_held();
        test_expected_change();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_truth_table_checker
